// File: rtl/fpu_lane_scheduler_pkg.sv
// Shared definitions for the dual-lane FPU scheduler: control encodings,
// the per-op latency table and the scheduler FSM state encoding.
package fpu_lane_scheduler_pkg;

  localparam logic [4:0] OP_NONE  = 5'b00000;
  localparam logic [4:0] OP_FADD  = 5'b00001;
  localparam logic [4:0] OP_FSUB  = 5'b00011;
  localparam logic [4:0] OP_FMUL  = 5'b00101;
  localparam logic [4:0] OP_FDIV  = 5'b00111;
  localparam logic [4:0] OP_FSQRT = 5'b01101;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;  // short ops only
  localparam state_t ST_SH1  = 2'd2;  // shared unit owned by lane 1
  localparam state_t ST_SH2  = 2'd3;  // shared unit owned by lane 2

  function automatic logic [4:0] op_latency(input logic [4:0] op,
                                            input logic [4:0] lat_short,
                                            input logic [4:0] lat_div,
                                            input logic [4:0] lat_sqrt);
    case (op)
      OP_FADD, OP_FSUB, OP_FMUL: return lat_short;
      OP_FDIV:                   return lat_div;
      OP_FSQRT:                  return lat_sqrt;
      default:                   return 5'd0;
    endcase
  endfunction

  function automatic logic op_is_long(input logic [4:0] op);
    return (op == OP_FDIV) || (op == OP_FSQRT);
  endfunction

endpackage

// File: rtl/fpu_lane_scheduler_lat_decode.sv
// Per-lane decoder: FPU control code -> stall latency and shared-unit flag.
module fpu_lat_decode
  import fpu_lane_scheduler_pkg::*;
#(
  parameter int LAT_FADD  = 1,
  parameter int LAT_FDIV  = 3,
  parameter int LAT_FSQRT = 2
) (
  input  logic [4:0] op,
  output logic [4:0] lat,
  output logic       is_long
);

  localparam logic [4:0] LAT_SHORT_W = LAT_FADD[4:0];
  localparam logic [4:0] LAT_DIV_W   = LAT_FDIV[4:0];
  localparam logic [4:0] LAT_SQRT_W  = LAT_FSQRT[4:0];

  assign lat     = op_latency(op, LAT_SHORT_W, LAT_DIV_W, LAT_SQRT_W);
  assign is_long = op_is_long(op);

endmodule

// File: rtl/fpu_lane_scheduler.sv
// Stall scheduler for two FPU lanes sharing one div/sqrt unit; holds the
// pipeline until both lanes finish and serialises contending long ops.
module fpu_lane_scheduler
  import fpu_lane_scheduler_pkg::*;
#(
  parameter int LAT_FADD  = 1,
  parameter int LAT_FDIV  = 3,
  parameter int LAT_FSQRT = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] op1,
  input  logic [4:0] op2,
  output logic       stall_o,
  output logic       u_start,
  output logic       u_sel,
  output logic       u_op,
  output logic       keep1,
  output logic       keep2,
  output logic       fstalled,
  output logic       read_data_keep
);

  state_t     state_q, state_d;
  logic [4:0] op1_q, op1_d, op2_q, op2_d;
  logic [4:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic       done1_q, done1_d, done2_q, done2_d;
  logic       fstalled_q;

  logic       is_idle;
  logic [4:0] op1_eff, op2_eff;
  logic [4:0] lat1, lat2;
  logic       long1, long2, both_long;
  logic       done1, done2, lane2_active;

  assign is_idle = (state_q == ST_IDLE);
  // Ops are only live in IDLE; once an episode starts the captured copies rule.
  assign op1_eff = is_idle ? op1 : op1_q;
  assign op2_eff = is_idle ? op2 : op2_q;

  fpu_lat_decode #(.LAT_FADD(LAT_FADD), .LAT_FDIV(LAT_FDIV), .LAT_FSQRT(LAT_FSQRT))
    u_dec1 (.op(op1_eff), .lat(lat1), .is_long(long1));
  fpu_lat_decode #(.LAT_FADD(LAT_FADD), .LAT_FDIV(LAT_FDIV), .LAT_FSQRT(LAT_FSQRT))
    u_dec2 (.op(op2_eff), .lat(lat2), .is_long(long2));

  assign both_long    = long1 & long2;
  assign done1        = (cnt1_q == lat1);
  assign done2        = (cnt2_q == lat2);
  // Lane 2 waits for the shared unit while lane 1 still owns it.
  assign lane2_active = !(both_long && !done1);
  assign stall_o      = !(done1 && done2);

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    done1_d = done1_q;
    done2_d = done2_q;
    u_start = 1'b0;
    u_sel   = (state_q == ST_SH2);

    if (stall_o) begin
      cnt1_d  = done1 ? cnt1_q : cnt1_q + 5'd1;
      cnt2_d  = (lane2_active && !done2) ? cnt2_q + 5'd1 : cnt2_q;
      done1_d = done1;
      done2_d = done2;
    end else begin
      state_d = ST_IDLE;
      cnt1_d  = 5'd0;
      cnt2_d  = 5'd0;
      done1_d = 1'b0;
      done2_d = 1'b0;
    end

    if (is_idle) begin
      op1_d = op1;
      op2_d = op2;
      if (stall_o) begin
        state_d = long1 ? ST_SH1 : (long2 ? ST_SH2 : ST_RUN);
        u_start = long1 | long2;
        u_sel   = !long1 && long2;
      end
    end else if (state_q == ST_SH1 && both_long && done1 && stall_o) begin
      state_d = ST_SH2;
      u_start = 1'b1;
      u_sel   = 1'b1;
    end
  end

  assign u_op  = ((u_sel ? op2_eff : op1_eff) == OP_FSQRT);
  // Completion edge only; a lane finishing in the release cycle needs no keep.
  assign keep1 = !is_idle && stall_o && (lat1 != 5'd0) && done1 && !done1_q;
  assign keep2 = !is_idle && stall_o && (lat2 != 5'd0) && done2 && !done2_q;

  assign fstalled       = fstalled_q;
  assign read_data_keep = stall_o && is_idle;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      op1_q      <= OP_NONE;
      op2_q      <= OP_NONE;
      cnt1_q     <= 5'd0;
      cnt2_q     <= 5'd0;
      done1_q    <= 1'b0;
      done2_q    <= 1'b0;
      fstalled_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      done1_q    <= done1_d;
      done2_q    <= done2_d;
      fstalled_q <= stall_o;
    end
  end

endmodule

// File: tb/tb_fpu_lane_scheduler.sv
// Directed bench for fpu_lane_scheduler with default latencies
// (fadd/fsub/fmul 1, fdiv 3, fsqrt 2); one check line per failing compare.
module tb_fpu_lane_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] op1, op2;
  logic       stall_o, u_start, u_sel, u_op, keep1, keep2, fstalled, read_data_keep;

  int tests = 0;
  int fails = 0;

  fpu_lane_scheduler dut (
    .clk(clk), .rstn(rstn), .op1(op1), .op2(op2),
    .stall_o(stall_o), .u_start(u_start), .u_sel(u_sel), .u_op(u_op),
    .keep1(keep1), .keep2(keep2), .fstalled(fstalled),
    .read_data_keep(read_data_keep)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Samples on the falling edge; u_sel/u_op only matter alongside u_start.
  task automatic chk_cyc(input string tag, input logic e_stall, input logic e_start,
                         input logic e_sel, input logic e_op, input logic e_k1,
                         input logic e_k2, input logic e_fst, input logic e_rdk);
    @(negedge clk);
    chk({tag, ".stall_o"}, stall_o, e_stall);
    chk({tag, ".u_start"}, u_start, e_start);
    if (e_start) begin
      chk({tag, ".u_sel"}, u_sel, e_sel);
      chk({tag, ".u_op"}, u_op, e_op);
    end
    chk({tag, ".keep1"}, keep1, e_k1);
    chk({tag, ".keep2"}, keep2, e_k2);
    chk({tag, ".fstalled"}, fstalled, e_fst);
    chk({tag, ".read_data_keep"}, read_data_keep, e_rdk);
    $display("[TB] %s op1=%b op2=%b stall=%b start=%b sel=%b uop=%b k1=%b k2=%b fst=%b rdk=%b",
             tag, op1, op2, stall_o, u_start, u_sel, u_op, keep1, keep2, fstalled, read_data_keep);
  endtask

  initial begin
    rstn = 1'b0; op1 = 5'd0; op2 = 5'd0;
    tick; tick;
    chk_cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    rstn = 1'b1;
    chk_cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // single fadd on lane 1
    op1 = 5'b00001; op2 = 5'b00000;
    chk_cyc("fadd.c0", 1, 0, 0, 0, 0, 0, 0, 1);
    tick; op1 = 5'd0;
    chk_cyc("fadd.c1", 0, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("fadd.c2", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // fdiv lane 1 + fmul lane 2
    op1 = 5'b00111; op2 = 5'b00101;
    chk_cyc("divmul.c0", 1, 1, 0, 0, 0, 0, 0, 1);
    tick; op1 = 5'd0; op2 = 5'd0;
    chk_cyc("divmul.c1", 1, 0, 0, 0, 0, 1, 1, 0);
    tick;
    chk_cyc("divmul.c2", 1, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("divmul.c3", 0, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("divmul.c4", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // fdiv lane 1 + fsqrt lane 2: contention on the shared unit
    op1 = 5'b00111; op2 = 5'b01101;
    chk_cyc("divsqrt.c0", 1, 1, 0, 0, 0, 0, 0, 1);
    tick; op1 = 5'd0; op2 = 5'd0;
    chk_cyc("divsqrt.c1", 1, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("divsqrt.c2", 1, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("divsqrt.c3", 1, 1, 1, 1, 1, 0, 1, 0);
    tick;
    chk_cyc("divsqrt.c4", 1, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("divsqrt.c5", 0, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("divsqrt.c6", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // undefined codes decode to zero latency
    op1 = 5'b01001; op2 = 5'b10001;
    chk_cyc("nop.c0", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk_cyc("nop.c1", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk_cyc("nop.c2", 0, 0, 0, 0, 0, 0, 0, 0);
    tick; op1 = 5'd0; op2 = 5'd0;

    // fsqrt alone on lane 1
    op1 = 5'b01101;
    chk_cyc("sqrt1.c0", 1, 1, 0, 1, 0, 0, 0, 1);
    tick; op1 = 5'd0;
    chk_cyc("sqrt1.c1", 1, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("sqrt1.c2", 0, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("sqrt1.c3", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // fsub lane 1 + fsqrt lane 2: shared unit on lane 2, keep1 mid-stall
    op1 = 5'b00011; op2 = 5'b01101;
    chk_cyc("subsqrt.c0", 1, 1, 1, 1, 0, 0, 0, 1);
    tick; op1 = 5'd0; op2 = 5'd0;
    chk_cyc("subsqrt.c1", 1, 0, 0, 0, 1, 0, 1, 0);
    tick;
    chk_cyc("subsqrt.c2", 0, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("subsqrt.c3", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // reset in the middle of a contended episode
    op1 = 5'b00111; op2 = 5'b01101;
    chk_cyc("rst.c0", 1, 1, 0, 0, 0, 0, 0, 1);
    tick; op1 = 5'd0; op2 = 5'd0;
    chk_cyc("rst.c1", 1, 0, 0, 0, 0, 0, 1, 0);
    tick; rstn = 1'b0;
    chk_cyc("rst.c2", 1, 0, 0, 0, 0, 0, 1, 0);
    tick; rstn = 1'b1;
    chk_cyc("rst.c3", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk_cyc("rst.c4", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // lane-1 op changes during a lane-2 fdiv stall are ignored
    op1 = 5'b00000; op2 = 5'b00111;
    chk_cyc("ign.c0", 1, 1, 1, 0, 0, 0, 0, 1);
    tick; op1 = 5'b00111; op2 = 5'd0;
    chk_cyc("ign.c1", 1, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("ign.c2", 1, 0, 0, 0, 0, 0, 1, 0);
    tick; op1 = 5'd0;
    chk_cyc("ign.c3", 0, 0, 0, 0, 0, 0, 1, 0);
    tick;
    chk_cyc("ign.c4", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_lane_scheduler.md
FPU_LANE_SCHEDULER -- requirements
Module: fpu_lane_scheduler

Interface
REQ-001 SHALL have parameter LAT_FADD, default 1: stall cycles for fadd/fsub/fmul.
REQ-002 SHALL have parameter LAT_FDIV, default 3: shared-unit cycles for fdiv.
REQ-003 SHALL have parameter LAT_FSQRT, default 2: shared-unit cycles for fsqrt.
REQ-004 SHALL have ports as follows; reset is rstn, synchronous, active-low; clock is clk.
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- op1  in  5  lane-1 FPU control in E stage (0 = no FP op)
- op2  in  5  lane-2 FPU control in E stage
- stall_o  out  1  hold F/D/E, flush M
- u_start  out  1  one-cycle start pulse to shared div/sqrt unit
- u_sel  out  1  shared-unit operand lane select (0 = lane1, 1 = lane2)
- u_op  out  1  shared-unit operation (0 = fdiv, 1 = fsqrt)
- keep1  out  1  capture lane-1 result into kept register
- keep2  out  1  capture lane-2 result into kept register
- fstalled  out  1  stall_o delayed one cycle (kept-register forwarding enable)
- read_data_keep  out  1  first cycle of a stall episode

Function
REQ-005 SHALL decode latency per lane: 00001/00011/00101 -> LAT_FADD; 00111 -> fdiv (long); 01101 -> fsqrt (long); all other codes -> 0.
REQ-006 SHALL treat fdiv/fsqrt as "long" ops that run only on the single shared unit; short ops run in per-lane units.
REQ-007 SHALL use FSM states IDLE, RUN (short counters only), SH1 (shared unit on lane 1), SH2 (shared unit on lane 2).
REQ-008 In IDLE with any nonzero latency, SHALL assert stall_o combinationally in that cycle (cycle 0) and leave IDLE.
REQ-009 SHALL start lane counters at 0 in cycle 0; a lane is done in the cycle its counter equals its latency.
REQ-010 If exactly one lane is long, SHALL pulse u_start in cycle 0 with u_sel = that lane; its latency counts from cycle 0.
REQ-011 If both lanes are long, SHALL give lane 1 the shared unit first (SH1), pulse u_start in cycle 0 (u_sel=0), then pulse u_start with u_sel=1 in the cycle lane 1 completes (SH2); lane 2 latency counts from that cycle.
REQ-012 Total stall SHALL equal max(lat1, lat2) cycles without contention, and lat1+lat2 cycles when both lanes are long.
REQ-013 stall_o SHALL drop in the first cycle in which every lane is done; FSM returns to IDLE with counters at 0 on the next edge.
REQ-014 keepN SHALL pulse for exactly one cycle when lane N completes while stall_o remains high; no pulse is issued when lane N completes in the release cycle.
REQ-015 fstalled SHALL equal stall_o registered; read_data_keep SHALL equal stall_o AND state==IDLE.
REQ-016 u_op SHALL reflect the op of the lane selected by u_sel; it is held stable while the shared unit is busy.
REQ-017 op1 and op2 SHALL be sampled only in IDLE; changes while stalled SHALL be ignored.
REQ-018 Counters SHALL be 5 bits and SHALL never wrap, because they saturate at the lane latency.

Reset
REQ-019 On rstn=0 at a clk edge, SHALL enter IDLE with counters 0 and fstalled 0; with op1=op2=0, all outputs are 0.
REQ-020 Reset mid-operation SHALL abandon the in-flight shared-unit op; no u_start or keep pulse follows reset.

Structure
REQ-021 FPU control encodings, the latency-table function and FSM state typedef SHALL live in the shared core package.
REQ-022 One sub-module, fpu_lat_decode (op -> latency, long flag), SHALL be instantiated once per lane.

Verification
REQ-023 op1=00001, op2=0 -> stall_o=1 in cycle 0 only; cycle 1 stall_o=0; keep1 never asserted; fstalled=1 in cycle 1.
REQ-024 op1=00111, op2=00101 -> u_start=1, u_sel=0, u_op=0 in cycle 0; keep2 in cycle 1; stall_o high cycles 0-2, low in cycle 3.
REQ-025 op1=00111, op2=01101 -> u_start in cycle 0 (u_sel=0) and cycle 3 (u_sel=1, u_op=1); keep1 in cycle 3; stall_o high cycles 0-4, low in cycle 5.
REQ-026 op1=01001, op2=10001 -> stall_o, u_start and keep* remain 0 throughout.
REQ-027 Both long, rstn=0 in cycle 2 -> cycle 3 IDLE, stall_o=0 (ops zeroed), and no u_start in cycle 3.
REQ-028 op1 changed to 00111 during a lane-2 fdiv stall -> ignored; a single episode of 3 stall cycles completes.
